led_matrix_scan: RTL and testbench



---
 rtl/led_pkg.sv | 20 ++
 rtl/led_frame_buffer.sv | 49 ++++
 rtl/led_matrix_scan.sv | 89 ++++++++
 tb/tb_led_matrix_scan.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared defaults for the LED matrix scanner and the PWM shift / configuration helpers.
package led_pkg;

    localparam int LED_ROWS        = 4;
    localparam int LED_COLS        = 8;
    localparam int LED_ROW_LOG2    = 11;
    localparam int LED_BRIGHT_BITS = 3;

    // Brightness steps are 2^shift phase counts wide; the top level stays below half a slot.
    function automatic int pwm_shift(input int row_log2, input int bright_bits);
        return row_log2 - 1 - bright_bits;
    endfunction

    function automatic bit cfg_ok(input int rows, input int cols, input int row_log2,
                                  input int bright_bits);
        return (rows >= 2) && (rows <= 16) && (cols >= 1) && (cols <= 32) &&
               (bright_bits >= 1) && (row_log2 >= bright_bits + 2);
    endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Double-buffered frame store: writes go to the back bank, the scanner reads the front bank.
module led_frame_buffer
    import led_pkg::*;
#(
    parameter int ROWS = LED_ROWS,
    parameter int COLS = LED_COLS
) (
    input  logic                    clk12MHz,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    flip,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [COLS-1:0]         rd_data
);

    logic [COLS-1:0] bank0 [ROWS];
    logic [COLS-1:0] bank1 [ROWS];
    logic            sel;
    logic            wr_ok;

    assign wr_ok = wr_en && (int'(wr_row) < ROWS);

    // sel names the front bank; a write in the flip cycle still targets the old back bank.
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            sel <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else begin
            if (flip) begin
                sel <= ~sel;
            end
            if (wr_ok) begin
                if (sel) begin
                    bank0[wr_row] <= wr_data;
                end else begin
                    bank1[wr_row] <= wr_data;
                end
            end
        end
    end

    assign rd_data = sel ? bank1[rd_row] : bank0[rd_row];

endmodule

// File: rtl/led_matrix_scan.sv
// Multiplexed LED matrix driver: row/phase scan, PWM with dark guard band, tear-free bank swap.
module led_matrix_scan
    import led_pkg::*;
#(
    parameter int ROWS        = LED_ROWS,
    parameter int COLS        = LED_COLS,
    parameter int ROW_LOG2    = LED_ROW_LOG2,
    parameter int BRIGHT_BITS = LED_BRIGHT_BITS
) (
    input  logic                    clk12MHz,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    swap_req,
    output logic                    swap_ack,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic                    frame_start,
    output logic [ROWS-1:0]         row_n,
    output logic [COLS-1:0]         col_n
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int SHIFT = pwm_shift(ROW_LOG2, BRIGHT_BITS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    if (!cfg_ok(ROWS, COLS, ROW_LOG2, BRIGHT_BITS)) begin : g_bad_cfg
        $error("led_matrix_scan: unsupported ROWS/COLS/ROW_LOG2/BRIGHT_BITS combination");
    end

    logic [ROW_LOG2-1:0] phase;
    logic [ROW_W-1:0]    row;
    logic                swap_pend;
    logic                started;
    logic                boundary;
    logic                do_swap;
    logic                lit;
    logic [ROW_LOG2-1:0] level;
    logic [ROW_LOG2-1:0] bright_ext;
    logic [ROWS-1:0]     lit_vec;
    logic [COLS-1:0]     front_row;

    assign boundary   = (row == LAST_ROW) && (&phase);
    assign do_swap    = boundary && (swap_pend || swap_req);
    assign level      = phase >> SHIFT;
    assign bright_ext = {{(ROW_LOG2 - BRIGHT_BITS){1'b0}}, brightness};
    // Phase 0 stays dark so the columns settle before the row driver turns on.
    assign lit        = (phase != '0) && (level < bright_ext);
    assign lit_vec    = {{(ROWS - 1){1'b0}}, lit};

    led_frame_buffer #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_frame_buffer (
        .clk12MHz (clk12MHz),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_data  (wr_data),
        .flip     (do_swap),
        .rd_row   (row),
        .rd_data  (front_row)
    );

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= '0;
            row         <= '0;
            swap_pend   <= 1'b0;
            started     <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            row_n       <= '1;
            col_n       <= '1;
        end else begin
            phase   <= phase + 1'b1;
            started <= 1'b1;
            if (&phase) begin
                row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end
            swap_pend   <= do_swap ? 1'b0 : (swap_pend | swap_req);
            swap_ack    <= do_swap;
            frame_start <= boundary | ~started;
            row_n       <= ~(lit_vec << row);
            col_n       <= ~front_row;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench: stimulus queues per-slot/per-frame expectations, monitors pop and compare.
module tb_led_matrix_scan;

    localparam int ROWS  = 4;
    localparam int COLS  = 8;
    localparam int SLOT  = 2048;
    localparam int FRAME = ROWS * SLOT;

    localparam int S_FRAME = 96;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, wr_en, swap_req, swap_ack, frame_start;
    logic [1:0]      wr_row;
    logic [COLS-1:0] wr_data, col_n;
    logic [2:0]      brightness;
    logic [ROWS-1:0] row_n;

    logic       s_rst_n, s_wr_en, s_swap_req, s_swap_ack, s_frame_start;
    logic [1:0] s_wr_row;
    logic [3:0] s_wr_data, s_col_n;
    logic [2:0] s_brightness;
    logic [2:0] s_row_n;

    led_matrix_scan u_dut (
        .clk12MHz    (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .brightness  (brightness),
        .frame_start (frame_start),
        .row_n       (row_n),
        .col_n       (col_n)
    );

    led_matrix_scan #(
        .ROWS        (3),
        .COLS        (4),
        .ROW_LOG2    (5),
        .BRIGHT_BITS (3)
    ) u_small (
        .clk12MHz    (clk),
        .rst_n       (s_rst_n),
        .wr_en       (s_wr_en),
        .wr_row      (s_wr_row),
        .wr_data     (s_wr_data),
        .swap_req    (s_swap_req),
        .swap_ack    (s_swap_ack),
        .brightness  (s_brightness),
        .frame_start (s_frame_start),
        .row_n       (s_row_n),
        .col_n       (s_col_n)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int        slot;
        int        on;
        logic [7:0] col;
    } slot_exp_t;

    typedef struct {
        int         frame;
        int         len;
        int         on;
        logic [11:0] cols;
    } frame_exp_t;

    slot_exp_t  sq[$];
    int         ack_q[$];
    frame_exp_t q2[$];

    // On-cycles per slot for brightness 0..7 with SHIFT = 7.
    int on_tab[8] = '{0, 127, 255, 383, 511, 639, 767, 895};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- main DUT monitor ----------------
    int         fidx = -1;
    int         cyc = 0;
    int         acc_on = 0;
    int         acc_row = -1;
    int         acc_multi = 0;
    logic [7:0] acc_col = '1;

    task automatic finalize(input int s, input int srow);
        slot_exp_t e;
        while (sq.size() > 0 && sq[0].slot < s) begin
            e = sq.pop_front();
            checks++;
            errors++;
            $display("FAIL slot_missed: slot %0d was never observed", e.slot);
        end
        if (sq.size() > 0 && sq[0].slot == s) begin
            e = sq.pop_front();
            check($sformatf("on_cycles slot%0d", s), acc_on, e.on);
            check($sformatf("col_n slot%0d", s), int'(acc_col), int'(e.col));
            if (e.on > 0) check($sformatf("lit_row slot%0d", s), acc_row, srow);
            check($sformatf("one_row_low slot%0d", s), acc_multi, 0);
        end
        acc_on    = 0;
        acc_row   = -1;
        acc_multi = 0;
    endtask

    always @(negedge clk) begin
        int nx;
        int ea;
        nx = cyc + 1;
        if (fidx >= 0 && nx <= FRAME) begin
            if (row_n != 4'hF) begin
                acc_on++;
                if ($countones(~row_n) != 1) acc_multi = 1;
                for (int r = 0; r < ROWS; r++) if (!row_n[r]) acc_row = r;
            end
            if ((nx % SLOT) == SLOT / 2) acc_col = col_n;
            if ((nx % SLOT) == 0) finalize(fidx * ROWS + nx / SLOT - 1, nx / SLOT - 1);
        end
        if (swap_ack) begin
            if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_swap_ack: ack at start of frame %0d, none expected", fidx + 1);
            end else begin
                ea = ack_q.pop_front();
                check("swap_ack_frame", fidx + 1, ea);
                check("ack_with_frame_start", int'(frame_start), 1);
            end
        end
        if (frame_start) begin
            fidx++;
            cyc       = 0;
            acc_on    = 0;
            acc_row   = -1;
            acc_multi = 0;
        end else begin
            cyc = nx;
        end
    end

    // ---------------- small DUT monitor (ROWS=3) ----------------
    int          s_fidx = -1;
    int          s_len = 0;
    int          s_on[3];
    logic [11:0] s_cols = '1;
    frame_exp_t  fe;
    bit          small_done = 1'b0;

    always @(negedge clk) begin
        if (s_frame_start) begin
            if (s_fidx >= 0 && q2.size() > 0 && q2[0].frame == s_fidx) begin
                fe = q2.pop_front();
                check("small_frame_len", s_len, fe.len);
                for (int r = 0; r < 3; r++) check($sformatf("small_on_row%0d", r), s_on[r], fe.on);
                check("small_cols", int'(s_cols), int'(fe.cols));
            end
            s_fidx++;
            s_len  = 0;
            s_on   = '{0, 0, 0};
            s_cols = '1;
        end
        s_len++;
        for (int r = 0; r < 3; r++) begin
            if (!s_row_n[r]) begin
                s_on[r]++;
                s_cols[r*4 +: 4] = s_col_n;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(inout int k);
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic adv(inout int k, input int target);
        while (k < target) step(k);
    endtask

    task automatic wait_fs(output int f);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < FRAME + 16 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (frame_start) seen = 1'b1;
        end
        check("frame_start_seen", int'(seen), 1);
        f = fidx + 1;
    endtask

    task automatic push_slot(input int f, input int r, input int on, input logic [7:0] col);
        slot_exp_t e;
        e.slot = f * ROWS + r;
        e.on   = on;
        e.col  = col;
        sq.push_back(e);
    endtask

    task automatic sweep(input int f, input int base, inout int k, input logic [7:0] p [4]);
        for (int s = 0; s < 4; s++) begin
            if (s > 0) adv(k, s * SLOT - 600);
            brightness = 3'(base + s);
            push_slot(f, s, on_tab[base + s], ~p[s]);
        end
    endtask

    // ---------------- small DUT stimulus ----------------
    initial begin : small_stim
        frame_exp_t e;
        s_rst_n = 1'b0; s_wr_en = 1'b0; s_wr_row = '0; s_wr_data = '0;
        s_swap_req = 1'b0; s_brightness = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        s_rst_n = 1'b1;
        for (int i = 0; i < 8 && !s_frame_start; i++) begin
            @(posedge clk);
            #1;
        end
        // rows 0..2, then an out-of-range row that must not disturb anything
        for (int r = 0; r < 4; r++) begin
            s_wr_en   = 1'b1;
            s_wr_row  = 2'(r);
            s_wr_data = (r == 3) ? 4'hF : 4'(1 << r);
            @(posedge clk);
            #1;
        end
        s_wr_en    = 1'b0;
        s_swap_req = 1'b1;
        @(posedge clk);
        #1;
        s_swap_req = 1'b0;
        // 3 rows x 32 cycles; brightness 7 lights p = 1..13
        for (int f = 1; f <= 2; f++) begin
            e.frame = f;
            e.len   = S_FRAME;
            e.on    = 13;
            e.cols  = 12'hBDE;
            q2.push_back(e);
        end
        for (int i = 0; i < 400 && s_fidx < 3; i++) @(posedge clk);
        check("small_frames_done", int'(s_fidx >= 3), 1);
        small_done = 1'b1;
    end

    // ---------------- main DUT stimulus ----------------
    initial begin : main_stim
        int         f;
        int         k;
        logic [7:0] pat [4];
        logic [7:0] pat2 [4];
        pat  = '{8'hA5, 8'h3C, 8'h0F, 8'h81};
        pat2 = '{8'h11, 8'h22, 8'h44, 8'h88};

        rst_n = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0;
        swap_req = 1'b0; brightness = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        check("reset_row_n", int'(row_n), 4'hF);
        check("reset_col_n", int'(col_n), 8'hFF);
        check("reset_swap_ack", int'(swap_ack), 0);
        check("reset_frame_start", int'(frame_start), 0);
        rst_n = 1'b1;

        // reset frame: banks empty -> columns dark; load back bank and request a flip
        wait_fs(f);
        k = 0;
        for (int r = 0; r < 3; r++) push_slot(f, r, 895, 8'hFF);
        for (int r = 0; r < 4; r++) begin
            wr_en = 1'b1; wr_row = 2'(r); wr_data = pat[r];
            step(k);
        end
        wr_en = 1'b0;
        swap_req = 1'b1;
        step(k);
        swap_req = 1'b0;
        ack_q.push_back(f + 1);

        // frame 1: new pattern displayed; prepare second pattern in the back bank
        wait_fs(f);
        k = 0;
        for (int r = 0; r < 4; r++) push_slot(f, r, 895, ~pat[r]);
        for (int r = 0; r < 4; r++) begin
            wr_en = 1'b1; wr_row = 2'(r); wr_data = pat2[r];
            step(k);
        end
        wr_en = 1'b0;

        // frames 2 and 3: brightness 0..7, one level per row slot
        wait_fs(f);
        k = 0;
        sweep(f, 0, k, pat);
        wait_fs(f);
        k = 0;
        sweep(f, 4, k, pat);

        // swap request exactly on the boundary cycle
        adv(k, FRAME - 1);
        swap_req = 1'b1;
        step(k);
        swap_req = 1'b0;
        check("boundary_frame_start", int'(frame_start), 1);
        ack_q.push_back(f + 1);
        f = f + 1;
        k = 0;

        // frame 4: second pattern, three requests collapse into one flip
        for (int r = 0; r < 4; r++) push_slot(f, r, 895, ~pat2[r]);
        adv(k, 100);    swap_req = 1'b1; step(k); swap_req = 1'b0;
        adv(k, 3000);   swap_req = 1'b1; step(k); swap_req = 1'b0;
        adv(k, 6000);   swap_req = 1'b1; step(k); swap_req = 1'b0;
        ack_q.push_back(f + 1);

        // frames 5..7: back-bank writes without a swap stay invisible
        wait_fs(f);
        k = 0;
        for (int r = 0; r < 4; r++) push_slot(f, r, 895, ~pat[r]);
        for (int r = 0; r < 4; r++) begin
            wr_en = 1'b1; wr_row = 2'(r); wr_data = 8'hFF;
            step(k);
        end
        wr_en = 1'b0;
        for (int n = 0; n < 2; n++) begin
            wait_fs(f);
            for (int r = 0; r < 4; r++) push_slot(f, r, 895, ~pat[r]);
        end

        // frame 8: pending swap, then reset while row 1 is lit
        wait_fs(f);
        k = 0;
        adv(k, 100);
        swap_req = 1'b1; step(k); swap_req = 1'b0;
        adv(k, SLOT + 300);
        check("lit_before_reset", int'(row_n), 4'b1101);
        rst_n = 1'b0;
        #1;
        check("async_reset_row_n", int'(row_n), 4'hF);
        check("async_reset_col_n", int'(col_n), 8'hFF);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // after release: restart at row 0, blank display, discarded swap never acks
        wait_fs(f);
        check("restart_frame_index", f, 9);
        for (int r = 0; r < 3; r++) push_slot(f, r, 895, 8'hFF);
        wait_fs(f);
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 1000 && !small_done; i++) @(posedge clk);
        check("small_bench_done", int'(small_done), 1);
        check("leftover_slot_expectations", sq.size(), 0);
        check("leftover_ack_expectations", ack_q.size(), 0);
        check("leftover_small_expectations", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
